// File: rtl/beat_seq_pkg.sv
// Shared definitions for the beat sequencer: state encoding and default widths.
package beat_seq_pkg;

  // Frame sequencing states, 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default width of the beats/pause/beatIndex fields.
  localparam int DEFAULT_BEATWIDTH = 8;

endpackage

// File: rtl/beat_sequencer_if.sv
// Control and address bus between the frame-start logic, the beat sequencer
// and the per-pixel datapath. The sequencer connects through the master
// modport (it owns the address bus); the controlling side uses slave.
interface beat_sequencer_if
  import beat_seq_pkg::*;
#(
  parameter int PIXELCOUNTERWIDTH = 20,
  parameter int BEATWIDTH         = DEFAULT_BEATWIDTH
) ();

  logic                         startCounterEn;
  logic                         abort;
  logic [BEATWIDTH-1:0]         beats;
  logic [BEATWIDTH-1:0]         pause;
  logic                         stall;
  logic                         process;
  logic                         started;
  logic [PIXELCOUNTERWIDTH-1:0] pixelCounter;
  logic [BEATWIDTH-1:0]         beatIndex;
  logic                         lastPixel;
  logic                         done;

  modport master (
    input  startCounterEn, abort, beats, pause, stall,
    output process, started, pixelCounter, beatIndex, lastPixel, done
  );

  modport slave (
    output startCounterEn, abort, beats, pause, stall,
    input  process, started, pixelCounter, beatIndex, lastPixel, done
  );

endinterface

// File: rtl/phase_counter.sv
// Saturating up-counter used for both the beat index and the pause gap.
// clear wins over enable; terminal flags that the count sits at the limit.
module phase_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  // Count register: clear to zero, otherwise step up until the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= CNT_ZERO;
    end else if (clear) begin
      count <= CNT_ZERO;
    end else if (enable && !terminal) begin
      count <= count + CNT_ONE;
    end else begin
      count <= count;
    end
  end

  assign terminal = (count == limit);

endmodule

// File: rtl/beat_sequencer.sv
// Walks pixel addresses MINPIXEL..MAXPIXEL, strobing process for a latched
// number of beats per pixel followed by a latched pause gap. Supports
// downstream stall, immediate abort and a one-cycle done pulse.
module beat_sequencer
  import beat_seq_pkg::*;
#(
  parameter int PIXELCOUNTERWIDTH = 20,
  parameter int MINPIXEL          = 0,
  parameter int MAXPIXEL          = 255,
  parameter int BEATWIDTH         = DEFAULT_BEATWIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  beat_sequencer_if.master bus
);

  localparam logic [PIXELCOUNTERWIDTH-1:0] MIN_ADDR  = PIXELCOUNTERWIDTH'(MINPIXEL);
  localparam logic [PIXELCOUNTERWIDTH-1:0] MAX_ADDR  = PIXELCOUNTERWIDTH'(MAXPIXEL);
  localparam logic [PIXELCOUNTERWIDTH-1:0] ADDR_ONE  = PIXELCOUNTERWIDTH'(1);
  localparam logic [BEATWIDTH-1:0]         BEAT_ZERO = {BEATWIDTH{1'b0}};
  localparam logic [BEATWIDTH-1:0]         BEAT_ONE  = BEATWIDTH'(1);

  state_t                       state;
  logic [PIXELCOUNTERWIDTH-1:0] pixel;
  logic [BEATWIDTH-1:0]         beats_lat;
  logic [BEATWIDTH-1:0]         pause_lat;

  logic [BEATWIDTH-1:0]         beat_count;
  logic [BEATWIDTH-1:0]         pause_count;
  logic                         beat_term;
  logic                         pause_term;
  logic [BEATWIDTH-1:0]         beat_limit;
  logic [BEATWIDTH-1:0]         pause_limit;

  logic                         beat_advance;
  logic                         beat_last;
  logic                         frame_end;
  logic                         pause_end;
  logic                         beat_clear;
  logic                         pause_clear;
  logic                         pause_enable;
  logic                         abort_active;

  // Decode per-cycle events from registered state; abort masks every other event.
  always_comb begin
    abort_active = (state != ST_IDLE) && bus.abort;
    beat_advance = (state == ST_BEAT) && !bus.stall && !bus.abort;
    beat_last    = beat_advance && beat_term;
    frame_end    = beat_last && (pixel == MAX_ADDR);
    pause_end    = (state == ST_PAUSE) && !bus.abort && pause_term;
    beat_clear   = ((state == ST_IDLE) && bus.startCounterEn) || abort_active ||
                   beat_last || pause_end;
    pause_clear  = (state != ST_PAUSE) || bus.abort || pause_end;
    pause_enable = (state == ST_PAUSE);
    // beats_lat is never 0; pause_limit is unused when pause_lat is 0
    // because PAUSE is never entered in that case.
    beat_limit   = beats_lat - BEAT_ONE;
    pause_limit  = pause_lat - BEAT_ONE;
  end

  phase_counter #(.WIDTH(BEATWIDTH)) u_beat_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (beat_clear),
    .enable   (beat_advance),
    .limit    (beat_limit),
    .count    (beat_count),
    .terminal (beat_term)
  );

  phase_counter #(.WIDTH(BEATWIDTH)) u_pause_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (pause_clear),
    .enable   (pause_enable),
    .limit    (pause_limit),
    .count    (pause_count),
    .terminal (pause_term)
  );

  // Frame FSM with pixel address register and start-time configuration latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pixel     <= MIN_ADDR;
      beats_lat <= BEAT_ONE;
      pause_lat <= BEAT_ZERO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.startCounterEn) begin
            beats_lat <= (bus.beats == BEAT_ZERO) ? BEAT_ONE : bus.beats;
            pause_lat <= bus.pause;
            pixel     <= MIN_ADDR;
            state     <= ST_BEAT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_BEAT: begin
          if (bus.abort) begin
            pixel <= MIN_ADDR;
            state <= ST_IDLE;
          end else if (frame_end) begin
            state <= ST_DONE;
          end else if (beat_last && (pause_lat == BEAT_ZERO)) begin
            pixel <= pixel + ADDR_ONE;
            state <= ST_BEAT;
          end else if (beat_last) begin
            state <= ST_PAUSE;
          end else begin
            state <= ST_BEAT;
          end
        end
        ST_PAUSE: begin
          if (bus.abort) begin
            pixel <= MIN_ADDR;
            state <= ST_IDLE;
          end else if (pause_end) begin
            pixel <= pixel + ADDR_ONE;
            state <= ST_BEAT;
          end else begin
            state <= ST_PAUSE;
          end
        end
        ST_DONE: begin
          if (bus.abort) begin
            pixel <= MIN_ADDR;
          end else begin
            pixel <= pixel;
          end
          state <= ST_IDLE;
        end
        default: begin
          pixel <= MIN_ADDR;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from registered state; only process sees stall directly.
  assign bus.process      = (state == ST_BEAT) && !bus.stall;
  assign bus.started      = (state != ST_IDLE);
  assign bus.pixelCounter = pixel;
  assign bus.beatIndex    = beat_count;
  assign bus.lastPixel    = (state != ST_IDLE) && (pixel == MAX_ADDR);
  assign bus.done         = (state == ST_DONE);

endmodule
